input_timing_frontend: RTL and testbench

- Upstream stage of gamelogic. Turns raw, bouncy active-low push-buttons into the clean single-cycle strobes gamelogic consumes: left_final, right_final, rot_final and tick_gravity.
- Covers debounce, left/right auto-repeat (DAS), and a level-scaled gravity timer with soft-drop.
- Outputs connect straight to the gamelogic inputs of the same name.

---
 rtl/input_timing_frontend.sv | 227 ++++++++++++++++++++++
 tb/tb_input_timing_frontend.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_timing_frontend.sv
`default_nettype none
// ============================================================================
// input_timing_frontend: debounce, left/right auto-repeat and gravity timing
// that produce single-cycle strobes for gamelogic.
// Revision: 1.0
// ============================================================================

module itf_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_level
);
    localparam int unsigned   CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          w_pressed;

    assign w_pressed = ~r_sync2;
    assign o_level   = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (w_pressed != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= w_pressed;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

module itf_das #(
    parameter int unsigned DAS_DELAY = 10,
    parameter int unsigned DAS_RATE  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_held,
    input  logic i_other,
    input  logic i_go,
    output logic o_strobe
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    localparam logic [31:0] C_DELAY_LOAD = 32'(DAS_DELAY - 1);
    localparam logic [31:0] C_RATE_LOAD  = 32'(DAS_RATE - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_timer;
    logic [31:0] w_timer_next;
    logic        w_strobe;

    assign o_strobe = w_strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // Pause, release and a simultaneous opposite press all park the FSM.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_strobe     = 1'b0;
        if (!i_run || !i_held || i_other) begin
            w_state_next = S_IDLE;
            w_timer_next = '0;
        end else if (i_go) begin
            w_strobe     = 1'b1;
            w_state_next = S_DELAY;
            w_timer_next = C_DELAY_LOAD;
        end else begin
            case (r_state)
                S_DELAY, S_REPEAT: begin
                    if (r_timer == '0) begin
                        w_strobe     = 1'b1;
                        w_state_next = S_REPEAT;
                        w_timer_next = C_RATE_LOAD;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end
endmodule

module input_timing_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DAS_DELAY       = 10000000,
    parameter int unsigned DAS_RATE        = 2500000,
    parameter int unsigned GRAV_BASE       = 25000000,
    parameter int unsigned GRAV_STEP       = 2000000,
    parameter int unsigned GRAV_MIN        = 2500000,
    parameter int unsigned SOFT_SHIFT      = 3
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       key_rot_n,
    input  logic       key_drop_n,
    input  logic [3:0] level,
    input  logic       run,
    output logic       left_final,
    output logic       right_final,
    output logic       rot_final,
    output logic       tick_gravity
);
    logic        w_deb_l, w_deb_r, w_deb_rot, w_deb_drop;
    logic        r_l_d, r_r_d, r_rot_d, r_both_d;
    logic        w_l_go, w_r_go, w_l_strobe, w_r_strobe;
    logic        r_left_final, r_right_final, r_rot_final, r_tick;
    logic [31:0] r_gcnt;
    logic [35:0] w_dec, w_base, w_min, w_period, w_shifted, w_eff, w_eff_m1;
    logic        w_grav_hit;

    itf_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .clk(CLOCK_50), .rst(resetn), .i_key_n(key_left_n), .o_level(w_deb_l));
    itf_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clk(CLOCK_50), .rst(resetn), .i_key_n(key_right_n), .o_level(w_deb_r));
    itf_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_rot (
        .clk(CLOCK_50), .rst(resetn), .i_key_n(key_rot_n), .o_level(w_deb_rot));
    itf_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_drop (
        .clk(CLOCK_50), .rst(resetn), .i_key_n(key_drop_n), .o_level(w_deb_drop));

    // A press starts a direction either on its own rising edge or when the
    // opposite key lets go of a two-key conflict while this one is still held.
    assign w_l_go = (w_deb_l & ~r_l_d) | r_both_d;
    assign w_r_go = (w_deb_r & ~r_r_d) | r_both_d;

    itf_das #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_das_l (
        .clk(CLOCK_50), .rst(resetn), .i_run(run), .i_held(w_deb_l),
        .i_other(w_deb_r), .i_go(w_l_go), .o_strobe(w_l_strobe));
    itf_das #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_das_r (
        .clk(CLOCK_50), .rst(resetn), .i_run(run), .i_held(w_deb_r),
        .i_other(w_deb_l), .i_go(w_r_go), .o_strobe(w_r_strobe));

    // Gravity period is evaluated in 36 bits so level*step can never wrap.
    always_comb begin
        w_dec     = 36'(level) * 36'(GRAV_STEP);
        w_base    = 36'(GRAV_BASE);
        w_min     = 36'(GRAV_MIN);
        w_period  = w_min;
        if (w_dec < w_base && (w_base - w_dec) > w_min) begin
            w_period = w_base - w_dec;
        end
        w_shifted = w_period >> SOFT_SHIFT;
        w_eff     = w_period;
        if (w_deb_drop) begin
            w_eff = (w_shifted == '0) ? 36'd1 : w_shifted;
        end
        w_eff_m1   = (w_eff == '0) ? '0 : (w_eff - 36'd1);
        w_grav_hit = ({4'd0, r_gcnt} >= w_eff_m1);
    end

    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            r_l_d         <= 1'b0;
            r_r_d         <= 1'b0;
            r_rot_d       <= 1'b0;
            r_both_d      <= 1'b0;
            r_left_final  <= 1'b0;
            r_right_final <= 1'b0;
            r_rot_final   <= 1'b0;
            r_tick        <= 1'b0;
            r_gcnt        <= '0;
        end else begin
            r_l_d         <= w_deb_l;
            r_r_d         <= w_deb_r;
            r_rot_d       <= w_deb_rot;
            r_both_d      <= w_deb_l & w_deb_r;
            r_left_final  <= w_l_strobe;
            r_right_final <= w_r_strobe;
            r_rot_final   <= run & w_deb_rot & ~r_rot_d;
            r_tick        <= 1'b0;
            if (run) begin
                if (w_grav_hit) begin
                    r_tick <= 1'b1;
                    r_gcnt <= '0;
                end else begin
                    r_gcnt <= r_gcnt + 32'd1;
                end
            end
        end
    end

    assign left_final   = r_left_final;
    assign right_final  = r_right_final;
    assign rot_final    = r_rot_final;
    assign tick_gravity = r_tick;
endmodule

`default_nettype wire

// File: tb/tb_input_timing_frontend.sv
`default_nettype none
// ============================================================================
// tb_input_timing_frontend: directed scoreboard bench for input_timing_frontend.
// Revision: 1.0
// ============================================================================
module tb_input_timing_frontend;
    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b1;
    logic       key_left_n = 1'b1, key_right_n = 1'b1, key_rot_n = 1'b1, key_drop_n = 1'b1;
    logic [3:0] level = 4'd0;
    logic       run = 1'b1;
    logic       left_final, right_final, rot_final, tick_gravity;

    typedef struct { int cyc; int sig; } evt_t;
    evt_t kq[$];
    int   gq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic grav_en = 1'b0;

    localparam int LAT = 7;   // debounce 4 + sync 2 + output register 1

    input_timing_frontend #(
        .DEBOUNCE_CYCLES(4), .DAS_DELAY(10), .DAS_RATE(3),
        .GRAV_BASE(20), .GRAV_STEP(2), .GRAV_MIN(4), .SOFT_SHIFT(2)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .key_left_n(key_left_n), .key_right_n(key_right_n),
        .key_rot_n(key_rot_n), .key_drop_n(key_drop_n),
        .level(level), .run(run),
        .left_final(left_final), .right_final(right_final),
        .rot_final(rot_final), .tick_gravity(tick_gravity)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_k(int c, int s);
        evt_t e;
        e.cyc = c;
        e.sig = s;
        kq.push_back(e);
    endtask

    task automatic key_evt(int sig);
        evt_t e;
        checks++;
        assert (kq.size() > 0) else begin
            failures++;
            $error("FAIL unexpected_strobe observed=sig%0d@%0d expected=none", sig, cyc);
        end
        if (kq.size() > 0) begin
            e = kq.pop_front();
            chk("strobe_sig", sig, e.sig);
            chk("strobe_cycle", cyc, e.cyc);
        end
    endtask

    task automatic grav_evt();
        int c;
        checks++;
        assert (gq.size() > 0) else begin
            failures++;
            $error("FAIL unexpected_tick observed=%0d expected=none", cyc);
        end
        if (gq.size() > 0) begin
            c = gq.pop_front();
            chk("tick_cycle", cyc, c);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            if (left_final)  key_evt(0);
            if (right_final) key_evt(1);
            if (rot_final)   key_evt(2);
        end
        if (grav_en && tick_gravity) grav_evt();
    end

    task automatic tick_n(int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic grav_setup(int lvl, logic drop);
        run        = 1'b0;
        level      = 4'(lvl);
        key_drop_n = ~drop;
        resetn     = 1'b1;
        tick_n(1);
        resetn     = 1'b0;
        tick_n(10);
        grav_en    = 1'b1;
    endtask

    task automatic grav_period(string tag, int lvl, logic drop, int e, int n);
        int k;
        grav_setup(lvl, drop);
        run = 1'b1;
        k = cyc;
        for (int i = 1; i <= n; i++) gq.push_back(k + e * i);
        tick_n(e * n);
        run = 1'b0;
        tick_n(2);
        chk(tag, gq.size(), 0);
        grav_en = 1'b0;
        gq.delete();
    endtask

    initial begin
        int t, t0, r, u, k;

        tick_n(3);
        chk("reset_left", left_final, 0);
        chk("reset_right", right_final, 0);
        chk("reset_rot", rot_final, 0);
        chk("reset_tick", tick_gravity, 0);
        resetn = 1'b0;
        mon_en = 1'b1;
        tick_n(2);

        // Bouncing rotate key, then a clean hold and release.
        for (int i = 0; i < 5; i++) begin
            key_rot_n = 1'b0; tick_n(2);
            key_rot_n = 1'b1; tick_n(2);
        end
        key_rot_n = 1'b0;
        push_k(cyc + LAT, 2);
        tick_n(20);
        key_rot_n = 1'b1;
        tick_n(15);
        chk("bounce_pending", kq.size(), 0);

        // Left auto-repeat.
        key_left_n = 1'b0;
        t  = cyc;
        t0 = t + LAT;
        r  = t0 + 22;
        push_k(t0, 0);
        for (int p = t0 + 10; p <= r + 6; p += 3) push_k(p, 0);
        tick_n(r - t);
        key_left_n = 1'b1;
        tick_n(15);
        chk("das_pending", kq.size(), 0);

        // Left held, right joins, left releases.
        key_left_n = 1'b0;
        t = cyc;
        push_k(t + LAT, 0);
        tick_n(5);
        key_right_n = 1'b0;
        tick_n(25);
        key_left_n = 1'b1;
        u = cyc;
        push_k(u + LAT, 1);
        push_k(u + LAT + 10, 1);
        push_k(u + LAT + 13, 1);
        push_k(u + LAT + 16, 1);
        tick_n(17);
        key_right_n = 1'b1;
        tick_n(15);
        chk("conflict_pending", kq.size(), 0);

        // Both pressed in the same cycle: silence.
        key_left_n = 1'b0; key_right_n = 1'b0;
        tick_n(20);
        key_left_n = 1'b1; key_right_n = 1'b1;
        tick_n(15);
        chk("both_pending", kq.size(), 0);

        // Keys pressed during pause stay silent after un-pause.
        run = 1'b0;
        key_rot_n = 1'b0; key_left_n = 1'b0;
        tick_n(12);
        run = 1'b1;
        tick_n(10);
        key_rot_n = 1'b1; key_left_n = 1'b1;
        tick_n(12);
        chk("pause_key_pending", kq.size(), 0);

        // Reset during DELAY, key held through reset release.
        key_left_n = 1'b0;
        tick_n(LAT);
        chk("pre_reset_left", left_final, 1);
        resetn = 1'b1;
        #1;
        chk("async_reset_left", left_final, 0);
        chk("async_reset_right", right_final, 0);
        chk("async_reset_rot", rot_final, 0);
        chk("async_reset_tick", tick_gravity, 0);
        tick_n(2);
        resetn = 1'b0;
        r = cyc;
        push_k(r + LAT, 0);
        tick_n(10);
        key_left_n = 1'b1;
        tick_n(15);
        chk("reset_hold_pending", kq.size(), 0);

        // Gravity periods.
        grav_period("grav_l0", 0, 1'b0, 20, 3);
        grav_period("grav_l5", 5, 1'b0, 10, 3);
        grav_period("grav_l15", 15, 1'b0, 4, 4);
        grav_period("grav_soft", 0, 1'b1, 5, 4);

        // Level jump with counter at 12.
        grav_setup(0, 1'b0);
        run = 1'b1;
        k = cyc;
        tick_n(12);
        level = 4'd8;
        gq.push_back(k + 13);
        gq.push_back(k + 17);
        gq.push_back(k + 21);
        tick_n(9);
        run = 1'b0;
        tick_n(2);
        chk("level_jump_pending", gq.size(), 0);
        grav_en = 1'b0;
        gq.delete();

        // Pause gravity at counter 7.
        grav_setup(0, 1'b0);
        run = 1'b1;
        k = cyc;
        tick_n(7);
        run = 1'b0;
        tick_n(50);
        run = 1'b1;
        gq.push_back(k + 70);
        gq.push_back(k + 90);
        tick_n(33);
        run = 1'b0;
        tick_n(2);
        chk("grav_pause_pending", gq.size(), 0);
        grav_en = 1'b0;
        chk("final_key_pending", kq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
